obi_arbiter: RTL and testbench

Round-robin arbiter that shares one OBI slave port between N_MST OBI masters (e.g. core instruction and data ports, debug module). Sits between the masters and the OBI-to-Wishbone bridge. Tracks exactly one outstanding transaction and routes the grant and response back to its owner. A response watchdog returns an error response if the slave never answers.

---
 rtl/obi_arbiter.sv | 142 ++++++++++++++
 tb/tb_obi_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_arbiter.sv
// Round-robin OBI arbiter: N_MST masters share one slave port.
// One outstanding transaction; response watchdog answers with an error.
module obi_arbiter #(
  parameter int N_MST       = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N_MST-1:0]           m_req_i,
  output logic [N_MST-1:0]           m_gnt_o,
  input  logic [N_MST*ADDR_W-1:0]    m_addr_i,
  input  logic [N_MST-1:0]           m_wr_en_i,
  input  logic [N_MST*DATA_W/8-1:0]  m_byte_en_i,
  input  logic [N_MST*DATA_W-1:0]    m_wdata_i,
  output logic [N_MST-1:0]           m_rvalid_o,
  output logic [N_MST-1:0]           m_err_o,
  output logic [DATA_W-1:0]          m_rdata_o,
  output logic                       s_req_o,
  input  logic                       s_gnt_i,
  output logic [ADDR_W-1:0]          s_addr_o,
  output logic                       s_wr_en_o,
  output logic [DATA_W/8-1:0]        s_byte_en_o,
  output logic [DATA_W-1:0]          s_wdata_o,
  input  logic                       s_rvalid_i,
  input  logic [DATA_W-1:0]          s_rdata_i,
  output logic                       busy_o,
  output logic [$clog2(N_MST)-1:0]   owner_o
);

  localparam int OW = $clog2(N_MST);
  localparam int BW = DATA_W / 8;
  localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DRAIN
  } state_t;

  state_t          r_state;
  logic [OW-1:0]   r_owner;
  logic [OW-1:0]   r_rr;
  logic [TW-1:0]   r_timer;

  logic            w_found;
  logic [OW-1:0]   w_pick;
  logic [OW-1:0]   w_j;
  logic [OW-1:0]   w_next;
  logic            w_expire;
  logic            w_tmo;

  // Scan downward so the lowest offset from r_rr wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_j     = '0;
    for (int i = N_MST - 1; i >= 0; i--) begin
      w_j = OW'((int'(r_rr) + i) % N_MST);
      if (m_req_i[w_j]) begin
        w_found = 1'b1;
        w_pick  = w_j;
      end
    end
  end

  assign w_next   = (r_owner == OW'(N_MST - 1)) ? '0 : r_owner + OW'(1);
  assign w_expire = (TIMEOUT_CYC > 0) &&
                    (r_timer == TW'(TIMEOUT_CYC - 1));
  assign w_tmo    = (r_state == RESP) && w_expire && !s_rvalid_i;

  assign s_req_o     = (r_state == REQ);
  assign busy_o      = (r_state != IDLE);
  assign owner_o     = r_owner;
  assign s_addr_o    = m_addr_i[int'(r_owner)*ADDR_W +: ADDR_W];
  assign s_wr_en_o   = m_wr_en_i[r_owner];
  assign s_byte_en_o = m_byte_en_i[int'(r_owner)*BW +: BW];
  assign s_wdata_o   = m_wdata_i[int'(r_owner)*DATA_W +: DATA_W];
  assign m_rdata_o   = w_tmo ? '0 : s_rdata_i;

  always_comb begin
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    m_err_o    = '0;
    if (!rst_i) begin
      if (r_state == REQ)
        m_gnt_o[r_owner] = s_gnt_i;
      if (r_state == RESP) begin
        m_rvalid_o[r_owner] = s_rvalid_i | w_tmo;
        m_err_o[r_owner]    = w_tmo;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_rr    <= '0;
      r_timer <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_found) begin
            r_owner <= w_pick;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (s_gnt_i) begin
            r_state <= RESP;
            r_timer <= '0;
          end else if (!m_req_i[r_owner]) begin
            r_state <= IDLE;
          end
        end
        RESP: begin
          if (s_rvalid_i || w_expire) begin
            r_rr    <= w_next;
            r_timer <= '0;
            r_state <= s_rvalid_i ? IDLE : DRAIN;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        DRAIN: begin
          // Absorb a late slave response so it never reaches the next owner.
          if (s_rvalid_i || w_expire) begin
            r_timer <= '0;
            r_state <= IDLE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obi_arbiter.sv
// Bench for obi_arbiter: directed scenarios plus randomized traffic,
// all checked each cycle against a behavioural arbiter model.
module tb_obi_arbiter;

  localparam int N  = 2;
  localparam int TC = 8;
  localparam int P_IDLE  = 0;
  localparam int P_REQ   = 1;
  localparam int P_RESP  = 2;
  localparam int P_DRAIN = 3;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  gnt_o;
  logic [63:0] addr;
  logic [1:0]  wr;
  logic [7:0]  be;
  logic [63:0] wd;
  logic [1:0]  rv_o;
  logic [1:0]  err_o;
  logic [31:0] rdata_o;
  logic        sreq_o;
  logic        sgnt;
  logic [31:0] saddr_o;
  logic        swr_o;
  logic [3:0]  sbe_o;
  logic [31:0] swd_o;
  logic        srv;
  logic [31:0] srd;
  logic        busy_o;
  logic        owner_o;

  obi_arbiter #(
    .N_MST(N), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TC)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .m_req_i(req), .m_gnt_o(gnt_o), .m_addr_i(addr),
    .m_wr_en_i(wr), .m_byte_en_i(be), .m_wdata_i(wd),
    .m_rvalid_o(rv_o), .m_err_o(err_o), .m_rdata_o(rdata_o),
    .s_req_o(sreq_o), .s_gnt_i(sgnt), .s_addr_o(saddr_o),
    .s_wr_en_o(swr_o), .s_byte_en_o(sbe_o), .s_wdata_o(swd_o),
    .s_rvalid_i(srv), .s_rdata_i(srd),
    .busy_o(busy_o), .owner_o(owner_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // model state
  int ph  = P_IDLE;
  int own = 0;
  int ptr = 0;
  int tmr = 0;

  // observations for directed checks
  int          cyc_n = 0;
  int          cnt_gnt [2];
  int          cnt_rv  [2];
  int          cnt_err [2];
  int          g_cyc, rv_cyc;
  logic [31:0] rv_rdata;
  logic [31:0] last_wd;
  logic [3:0]  last_be;
  logic        last_wr;
  logic [1:0]  prev_gnt;
  int          gorder[$];
  logic [31:0] gaddr[$];

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic clr();
    for (int k = 0; k < 2; k++) begin
      cnt_gnt[k] = 0;
      cnt_rv[k]  = 0;
      cnt_err[k] = 0;
    end
    gorder.delete();
    gaddr.delete();
    rv_rdata = '0;
  endtask

  // One clock: compare at negedge, advance model at posedge.
  task automatic cyc();
    logic [1:0]  eg, er, ee;
    logic        tmo;
    logic [31:0] erd;
    @(negedge clk);
    prev_gnt = '0;
    if (!rst) begin
      eg  = '0;
      er  = '0;
      ee  = '0;
      tmo = (ph == P_RESP) && (tmr == TC - 1) && !srv;
      if (ph == P_REQ && sgnt) eg[own] = 1'b1;
      if (ph == P_RESP && (srv || tmo)) er[own] = 1'b1;
      if (tmo) ee[own] = 1'b1;
      erd = tmo ? 32'h0 : srd;
      check("s_req", sreq_o, ph == P_REQ);
      check("busy", busy_o, ph != P_IDLE);
      check("owner", owner_o, own);
      check("gnt", gnt_o, eg);
      check("rvalid", rv_o, er);
      check("err", err_o, ee);
      if (ph == P_RESP) check("rdata", rdata_o, erd);
      if (ph == P_REQ) begin
        check("s_addr", saddr_o, addr[own*32 +: 32]);
        check("s_wr", swr_o, wr[own]);
        check("s_be", sbe_o, be[own*4 +: 4]);
        check("s_wdata", swd_o, wd[own*32 +: 32]);
      end
      prev_gnt = gnt_o;
      for (int k = 0; k < 2; k++) begin
        if (gnt_o[k]) begin
          cnt_gnt[k]++;
          gorder.push_back(k);
          gaddr.push_back(saddr_o);
          g_cyc = cyc_n;
        end
        if (rv_o[k]) begin
          cnt_rv[k]++;
          rv_rdata = rdata_o;
          rv_cyc   = cyc_n;
        end
        if (err_o[k]) cnt_err[k]++;
      end
      if (sreq_o) begin
        last_wd = swd_o;
        last_be = sbe_o;
        last_wr = swr_o;
      end
    end
    @(posedge clk);
    cyc_n++;
    if (rst) begin
      ph = P_IDLE; own = 0; ptr = 0; tmr = 0;
    end else begin
      case (ph)
        P_IDLE: begin
          for (int off = N - 1; off >= 0; off--)
            if (req[(ptr + off) % N]) begin
              own = (ptr + off) % N;
              ph  = P_REQ;
            end
        end
        P_REQ: begin
          if (sgnt) begin
            ph = P_RESP; tmr = 0;
          end else if (!req[own]) begin
            ph = P_IDLE;
          end
        end
        P_RESP: begin
          if (srv || tmr == TC - 1) begin
            ptr = (own + 1) % N;
            ph  = srv ? P_IDLE : P_DRAIN;
            tmr = 0;
          end else begin
            tmr++;
          end
        end
        default: begin
          if (srv || tmr == TC - 1) begin
            ph = P_IDLE; tmr = 0;
          end else begin
            tmr++;
          end
        end
      endcase
    end
    #1;
  endtask

  // Simple slave: grant immediately, answer on first response cycle.
  task automatic serve(input int max_cyc, input int n_gnt);
    for (int c = 0; c < max_cyc; c++) begin
      if (gorder.size() >= n_gnt && !busy_o) break;
      if (gorder.size() >= n_gnt) req = 2'b00;
      sgnt = sreq_o;
      srv  = busy_o && !sreq_o;
      srd  = $urandom;
      cyc();
    end
    sgnt = 1'b0;
    srv  = 1'b0;
    req  = 2'b00;
  endtask

  initial begin
    int mode;
    rst = 1'b1; req = '0; addr = '0; wr = '0; be = '0; wd = '0;
    sgnt = 1'b0; srv = 1'b0; srd = '0;
    clr();
    @(posedge clk);
    #1;
    cyc();
    cyc();
    rst = 1'b0;
    check("rst_busy", busy_o, 1'b0);
    check("rst_sreq", sreq_o, 1'b0);
    check("rst_gnt", gnt_o, 2'b00);
    check("rst_owner", owner_o, 1'b0);
    cyc();

    // single read by master 0
    clr();
    req = 2'b01; addr[31:0] = 32'h0000_1000;
    cyc(); cyc(); cyc();
    sgnt = 1'b1; cyc();
    sgnt = 1'b0; req = 2'b00;
    cyc(); cyc();
    srv = 1'b1; srd = 32'hCAFE_F00D; cyc();
    srv = 1'b0; cyc(); cyc();
    check("rd_gnt0", cnt_gnt[0], 1);
    check("rd_rv0", cnt_rv[0], 1);
    check("rd_rdata", rv_rdata, 32'hCAFE_F00D);
    check("rd_err0", cnt_err[0], 0);
    check("rd_m1", cnt_gnt[1] + cnt_rv[1], 0);
    if (gaddr.size() > 0) check("rd_addr", gaddr[0], 32'h0000_1000);

    // contention from reset
    rst = 1'b1; cyc(); rst = 1'b0;
    clr();
    req = 2'b11; addr = {32'hB000_0004, 32'hA000_0000};
    serve(60, 4);
    check("cont_n", gorder.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < gorder.size()) begin
        check("cont_order", gorder[i], i % 2);
        check("cont_addr", gaddr[i],
              (i % 2) ? 32'hB000_0004 : 32'hA000_0000);
      end

    // write mux from master 1
    clr();
    req = 2'b10; wr = 2'b10; be = 8'h30;
    wd = {32'h1234_5678, 32'h0}; addr[63:32] = 32'h2000;
    cyc(); cyc();
    sgnt = 1'b1; cyc();
    sgnt = 1'b0; req = 2'b00; wr = 2'b00;
    srv = 1'b1; cyc();
    srv = 1'b0; cyc();
    check("wr_wdata", last_wd, 32'h1234_5678);
    check("wr_be", last_be, 4'h3);
    check("wr_en", last_wr, 1'b1);
    check("wr_gnt1", cnt_gnt[1], 1);
    check("wr_rv1", cnt_rv[1], 1);

    // timeout, late response swallowed, then normal service
    clr();
    req = 2'b01; srd = 32'hDEAD_BEEF;
    cyc();
    sgnt = 1'b1; cyc();
    sgnt = 1'b0; req = 2'b00;
    for (int c = 0; c < 12 && cnt_err[0] == 0; c++) cyc();
    check("to_delay", rv_cyc - g_cyc, 8);
    check("to_rv", cnt_rv[0], 1);
    check("to_err", cnt_err[0], 1);
    check("to_rdata", rv_rdata, 32'h0);
    cyc(); cyc();
    srv = 1'b1; srd = 32'h5555_AAAA; cyc();
    srv = 1'b0; cyc();
    check("late_swallow", cnt_rv[0] + cnt_rv[1], 1);
    req = 2'b01; cyc();
    sgnt = 1'b1; cyc();
    sgnt = 1'b0; req = 2'b00;
    srv = 1'b1; srd = 32'h600D_600D; cyc();
    srv = 1'b0; cyc();
    check("after_rv", cnt_rv[0], 2);
    check("after_err", cnt_err[0], 1);
    check("after_rdata", rv_rdata, 32'h600D_600D);

    // reset while master 1 awaits a response
    clr();
    req = 2'b10; cyc();
    sgnt = 1'b1; cyc();
    sgnt = 1'b0; req = 2'b00; cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    check("mr_busy", busy_o, 1'b0);
    check("mr_sreq", sreq_o, 1'b0);
    check("mr_owner", owner_o, 1'b0);
    check("mr_rv", rv_o, 2'b00);
    clr();
    req = 2'b11;
    serve(20, 1);
    if (gorder.size() > 0) check("mr_first", gorder[0], 0);
    check("mr_rv1", cnt_rv[1], 0);

    // master 0 aborts before grant
    rst = 1'b1; cyc(); rst = 1'b0;
    clr();
    req = 2'b11; cyc(); cyc();
    req = 2'b10; cyc(); cyc();
    sgnt = 1'b1; cyc();
    sgnt = 1'b0; req = 2'b00;
    srv = 1'b1; cyc();
    srv = 1'b0; cyc();
    check("ab_gnt0", cnt_gnt[0], 0);
    check("ab_gnt1", cnt_gnt[1], 1);
    if (gorder.size() > 0) check("ab_first", gorder[0], 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      mode = (i / 250) % 3;
      rst  = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < 2; k++) begin
        if (req[k]) begin
          if ((prev_gnt[k] && $urandom_range(0, 1) == 0) ||
              $urandom_range(0, 29) == 0)
            req[k] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req[k] = 1'b1;
        end
      end
      addr = {$urandom, $urandom};
      wd   = {$urandom, $urandom};
      be   = 8'($urandom);
      wr   = 2'($urandom);
      sgnt = $urandom_range(0, 1) == 1;
      srd  = $urandom;
      case (mode)
        0:       srv = $urandom_range(0, 9) < 3;
        1:       srv = $urandom_range(0, 19) == 0;
        default: srv = 1'b0;
      endcase
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
